// File: rtl/video_ycbcr_pkg.sv
// Shared constants and helpers for the RGB888 -> YCbCr444 converter.
// The studio clamp helper is only used when YCBCR_STUDIO_CLIP_EN is defined.
package video_ycbcr_pkg;

  // Default BT.601 full-range coefficients, scaled by 256
  localparam int unsigned DEF_Y_R  = 77;
  localparam int unsigned DEF_Y_G  = 150;
  localparam int unsigned DEF_Y_B  = 29;
  localparam int unsigned DEF_CB_R = 43;
  localparam int unsigned DEF_CB_G = 85;
  localparam int unsigned DEF_CB_B = 128;
  localparam int unsigned DEF_CR_R = 128;
  localparam int unsigned DEF_CR_G = 107;
  localparam int unsigned DEF_CR_B = 21;

  localparam int unsigned LATENCY  = 3;
  localparam int unsigned SUM_W    = 16;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned SYNC_W   = 3;
  localparam int unsigned N_PROD   = 9;

  localparam logic [PIX_W-1:0] CLAMP_LO   = 8'd16;
  localparam logic [PIX_W-1:0] CLAMP_Y_HI = 8'd235;
  localparam logic [PIX_W-1:0] CLAMP_C_HI = 8'd240;

  // Offset that recentres the signed chroma difference into unsigned range
  localparam logic [SUM_W-1:0] CHROMA_OFS = 16'h8000;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  function automatic logic [PIX_W-1:0] clamp8(
    input logic [PIX_W-1:0] v,
    input logic [PIX_W-1:0] lo,
    input logic [PIX_W-1:0] hi
  );
    logic [PIX_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/video_rgb888_to_ycbcr444_if.sv
// Pixel-stream bundles: RGB888 input side and YCbCr444 output side.
// Each carries the frame strobes alongside the pixel data.
interface video_rgb_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output per_img_red, per_img_green, per_img_blue
  );
  modport slave (
    input per_frame_vsync, per_frame_href, per_frame_clken,
    input per_img_red, per_img_green, per_img_blue
  );
endinterface

interface video_ycbcr_if;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_Y;
  logic [7:0] post_img_Cb;
  logic [7:0] post_img_Cr;

  modport master (
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_img_Y, post_img_Cb, post_img_Cr
  );
  modport slave (
    input post_frame_vsync, post_frame_href, post_frame_clken,
    input post_img_Y, post_img_Cb, post_img_Cr
  );
endinterface

// File: rtl/video_sync_delay.sv
// DEPTH x WIDTH shift register with asynchronous active-low clear,
// used to keep the frame strobes aligned with the pixel pipeline.
module video_sync_delay #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH-1:0][WIDTH-1:0] shift_q;
  logic [DEPTH-1:0][WIDTH-1:0] shift_d;

  generate
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign shift_d[gi] = din_i;
      end else begin : g_tail
        assign shift_d[gi] = shift_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout_o = shift_q[DEPTH-1];

endmodule

// File: rtl/video_rgb888_to_ycbcr444.sv
// Three-stage RGB888 -> YCbCr444 converter (multiply, sum, truncate/gate).
// Define YCBCR_STUDIO_CLIP_EN to clamp results to studio range in the last stage.
module video_rgb888_to_ycbcr444
  import video_ycbcr_pkg::*;
#(
  parameter int unsigned Y_R  = DEF_Y_R,
  parameter int unsigned Y_G  = DEF_Y_G,
  parameter int unsigned Y_B  = DEF_Y_B,
  parameter int unsigned CB_R = DEF_CB_R,
  parameter int unsigned CB_G = DEF_CB_G,
  parameter int unsigned CB_B = DEF_CB_B,
  parameter int unsigned CR_R = DEF_CR_R,
  parameter int unsigned CR_G = DEF_CR_G,
  parameter int unsigned CR_B = DEF_CR_B
) (
  input  logic               clk,
  input  logic               rst_n,
  video_rgb_if.slave         rgb_in,
  video_ycbcr_if.master      ycc_out
);

  // Product order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B); low byte is index 0
  localparam logic [N_PROD*PIX_W-1:0] COEF_VEC = {
    8'(CR_B), 8'(CR_G), 8'(CR_R),
    8'(CB_B), 8'(CB_G), 8'(CB_R),
    8'(Y_B),  8'(Y_G),  8'(Y_R)
  };

  logic [3*PIX_W-1:0] pix;
  assign pix = {rgb_in.per_img_blue, rgb_in.per_img_green, rgb_in.per_img_red};

  // Stage 1: nine registered 8x8 products
  generate
    genvar gi;
    for (gi = 0; gi < N_PROD; gi++) begin : g_prod
      logic [SUM_W-1:0] prod_d;
      logic [SUM_W-1:0] prod_q;

      assign prod_d = SUM_W'(pix[(gi % 3)*PIX_W +: PIX_W])
                    * SUM_W'(COEF_VEC[gi*PIX_W +: PIX_W]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_q <= '0;
        end else begin
          prod_q <= prod_d;
        end
      end
    end
  endgenerate

  // Stage 2: sums; offset is added first so the chroma difference never goes negative
  logic [SUM_W-1:0] y_sum_d,  y_sum_q;
  logic [SUM_W-1:0] cb_sum_d, cb_sum_q;
  logic [SUM_W-1:0] cr_sum_d, cr_sum_q;

  assign y_sum_d  = g_prod[0].prod_q + g_prod[1].prod_q + g_prod[2].prod_q;
  assign cb_sum_d = (g_prod[5].prod_q + CHROMA_OFS)
                  - (g_prod[3].prod_q + g_prod[4].prod_q);
  assign cr_sum_d = (g_prod[6].prod_q + CHROMA_OFS)
                  - (g_prod[7].prod_q + g_prod[8].prod_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sum_q  <= '0;
      cb_sum_q <= '0;
      cr_sum_q <= '0;
    end else begin
      y_sum_q  <= y_sum_d;
      cb_sum_q <= cb_sum_d;
      cr_sum_q <= cr_sum_d;
    end
  end

  // Stage 3: truncate to the high byte, optionally clamp
  logic [PIX_W-1:0] y_d,  y_q;
  logic [PIX_W-1:0] cb_d, cb_q;
  logic [PIX_W-1:0] cr_d, cr_q;

`ifdef YCBCR_STUDIO_CLIP_EN
  assign y_d  = clamp8(y_sum_q[SUM_W-1 -: PIX_W],  CLAMP_LO, CLAMP_Y_HI);
  assign cb_d = clamp8(cb_sum_q[SUM_W-1 -: PIX_W], CLAMP_LO, CLAMP_C_HI);
  assign cr_d = clamp8(cr_sum_q[SUM_W-1 -: PIX_W], CLAMP_LO, CLAMP_C_HI);
`else
  assign y_d  = y_sum_q[SUM_W-1 -: PIX_W];
  assign cb_d = cb_sum_q[SUM_W-1 -: PIX_W];
  assign cr_d = cr_sum_q[SUM_W-1 -: PIX_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= '0;
      cb_q <= '0;
      cr_q <= '0;
    end else begin
      y_q  <= y_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
    end
  end

  sync_t sync_in;
  sync_t sync_out;

  assign sync_in.vsync = rgb_in.per_frame_vsync;
  assign sync_in.href  = rgb_in.per_frame_href;
  assign sync_in.clken = rgb_in.per_frame_clken;

  video_sync_delay #(
    .DEPTH (LATENCY),
    .WIDTH (SYNC_W)
  ) u_sync_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (sync_in),
    .dout_o (sync_out)
  );

  assign ycc_out.post_frame_vsync = sync_out.vsync;
  assign ycc_out.post_frame_href  = sync_out.href;
  assign ycc_out.post_frame_clken = sync_out.clken;

  // Data is blanked outside active lines so downstream never sees stale pixels
  assign ycc_out.post_img_Y  = sync_out.href ? y_q  : '0;
  assign ycc_out.post_img_Cb = sync_out.href ? cb_q : '0;
  assign ycc_out.post_img_Cr = sync_out.href ? cr_q : '0;

endmodule

// File: tb/tb_video_rgb888_to_ycbcr444.sv
// Scoreboard bench for video_rgb888_to_ycbcr444: expectations queued at drive
// time and compared three clocks later; honours YCBCR_STUDIO_CLIP_EN.
module tb_video_rgb888_to_ycbcr444;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_rgb_if   rgb_if ();
  video_ycbcr_if ycc_if ();

  video_rgb888_to_ycbcr444 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rgb_in  (rgb_if.slave),
    .ycc_out (ycc_if.master)
  );

  typedef struct {
    logic [2:0] sync;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn      = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic exp_t model(input logic v, input logic h, input logic c,
                                 input int r, input int g, input int b);
    exp_t e;
    int y, cb, cr;
    y  = (77*r + 150*g + 29*b) / 256;
    cb = (128*b + 32768 - 43*r - 85*g) / 256;
    cr = (128*r + 32768 - 107*g - 21*b) / 256;
`ifdef YCBCR_STUDIO_CLIP_EN
    y  = clampi(y, 16, 235);
    cb = clampi(cb, 16, 240);
    cr = clampi(cr, 16, 240);
`endif
    e.sync = {v, h, c};
    e.y  = h ? 8'(y)  : 8'd0;
    e.cb = h ? 8'(cb) : 8'd0;
    e.cr = h ? 8'(cr) : 8'd0;
    return e;
  endfunction

  function automatic int out_word();
    return int'({ycc_if.post_frame_vsync, ycc_if.post_frame_href, ycc_if.post_frame_clken,
                 ycc_if.post_img_Y, ycc_if.post_img_Cb, ycc_if.post_img_Cr});
  endfunction

  // Pipeline registers are cleared, so the next two outputs are all-zero
  task automatic reset_sb();
    exp_t z;
    z.sync = 3'b000; z.y = 8'd0; z.cb = 8'd0; z.cr = 8'd0;
    sb_q.delete();
    sb_q.push_back(z);
    sb_q.push_back(z);
  endtask

  task automatic drive(input logic v, input logic h, input logic c,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input exp_t e);
    exp_t x;
    rgb_if.per_frame_vsync = v;
    rgb_if.per_frame_href  = h;
    rgb_if.per_frame_clken = c;
    rgb_if.per_img_red     = r;
    rgb_if.per_img_green   = g;
    rgb_if.per_img_blue    = b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() >= 3) begin
      x = sb_q.pop_front();
      $display("txn %0d sync=%b Y=%0d Cb=%0d Cr=%0d", txn,
               {ycc_if.post_frame_vsync, ycc_if.post_frame_href, ycc_if.post_frame_clken},
               ycc_if.post_img_Y, ycc_if.post_img_Cb, ycc_if.post_img_Cr);
      check_val($sformatf("sync#%0d", txn),
                int'({ycc_if.post_frame_vsync, ycc_if.post_frame_href, ycc_if.post_frame_clken}),
                int'(x.sync));
      check_val($sformatf("Y#%0d", txn),  int'(ycc_if.post_img_Y),  int'(x.y));
      check_val($sformatf("Cb#%0d", txn), int'(ycc_if.post_img_Cb), int'(x.cb));
      check_val($sformatf("Cr#%0d", txn), int'(ycc_if.post_img_Cr), int'(x.cr));
      txn++;
    end
  endtask

  task automatic rnd(input logic v, input logic h, input logic c);
    int r, g, b;
    r = $urandom_range(0, 255);
    g = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    drive(v, h, c, 8'(r), 8'(g), 8'(b), model(v, h, c, r, g, b));
  endtask

  task automatic px(input int r, input int g, input int b,
                    input int y, input int cb, input int cr);
    exp_t e;
    e.sync = 3'b011; e.y = 8'(y); e.cb = 8'(cb); e.cr = 8'(cr);
    drive(1'b0, 1'b1, 1'b1, 8'(r), 8'(g), 8'(b), e);
  endtask

  initial begin
    rgb_if.per_frame_vsync = 1'b0;
    rgb_if.per_frame_href  = 1'b0;
    rgb_if.per_frame_clken = 1'b0;
    rgb_if.per_img_red     = 8'd0;
    rgb_if.per_img_green   = 8'd0;
    rgb_if.per_img_blue    = 8'd0;

    // Held in reset with live traffic: everything must read zero
    for (int i = 0; i < 5; i++) begin
      rgb_if.per_frame_vsync = 1'($urandom_range(0, 1));
      rgb_if.per_frame_href  = 1'b1;
      rgb_if.per_frame_clken = 1'b1;
      rgb_if.per_img_red     = 8'($urandom_range(0, 255));
      rgb_if.per_img_green   = 8'($urandom_range(0, 255));
      rgb_if.per_img_blue    = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check_val("rst_hold", out_word(), 0);
    end

    rst_n = 1'b1;
    reset_sb();
    repeat (3) rnd(1'b0, 1'b0, 1'b0);

`ifdef YCBCR_STUDIO_CLIP_EN
    px(255, 255, 255, 235, 128, 128);
    px(0,   0,   0,   16,  128, 128);
    px(255, 0,   0,   76,  85,  240);
    px(0,   0,   255, 28,  240, 107);
`else
    px(255, 255, 255, 255, 128, 128);
    px(0,   0,   0,   0,   128, 128);
    px(255, 0,   0,   76,  85,  255);
    px(0,   0,   255, 28,  255, 107);
`endif

    for (int i = 0; i < 20; i++) rnd(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));

    repeat (2) rnd(1'b1, 1'b0, 1'b0);
    repeat (3) rnd(1'b0, 1'b0, 1'b0);

    // Full line with alternating clken, then blanking
    for (int i = 0; i < 640; i++) rnd(1'b0, 1'b1, 1'(i % 2 == 0));
    repeat (4) rnd(1'b0, 1'b0, 1'b1);

    // Reset pulled mid-line: outputs must clear without waiting for a clock
    repeat (10) rnd(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("rst_async", out_word(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_val("rst_mid", out_word(), 0);
    end
    rst_n = 1'b1;
    reset_sb();
    repeat (6) rnd(1'b0, 1'b1, 1'b1);
    repeat (4) rnd(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
